// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_stall_ctrl_pkg
// Brief   : Shared encodings and constants for the DLX pipeline sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MUL_DONE = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam logic [4:0] LINK_REG    = 5'd31;
  localparam int         MUL_LAT_DEF = 4;
  localparam int         MUL_CNT_W   = 5;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up counter that sticks at all-ones instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_stall_ctrl
// Brief   : ID-stage sequencer: load-use bubbles, multiplier freeze, redirect
//           flush and saturating stall/flush performance counters.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_RegWrite,
  input  logic             ex_MemToReg,
  input  logic             ex_mul,
  input  logic             ex_redirect,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             idex_write_en,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             exmem_bubble,
  output logic             mul_start,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_t                 r_state;
  logic [MUL_CNT_W-1:0]   r_cnt;
  logic                   w_mul_go;
  logic                   w_redirect;
  logic                   w_load_use;
  logic                   w_stall_inc;

  assign w_mul_go   = ex_valid & ex_mul;
  assign w_redirect = ex_valid & ex_redirect;
  assign w_load_use = ex_valid & ex_RegWrite & ex_MemToReg & (ex_rd != REG_ZERO) &
                      id_valid &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

  // The IDLE cycle that sees the mul is the first freeze cycle, hence MUL_LAT-2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mul_go) begin
            r_cnt   <= MUL_CNT_W'(MUL_LAT - 2);
            r_state <= (MUL_LAT == 2) ? ST_MUL_DONE : ST_MUL_BUSY;
          end
        end
        ST_MUL_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == MUL_CNT_W'(1)) begin
            r_state <= ST_MUL_DONE;
          end
        end
        ST_MUL_DONE: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the decode so outputs return to pass-through without a clock.
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_write_en = 1'b1;
    idex_bubble   = 1'b0;
    ifid_flush    = 1'b0;
    exmem_bubble  = 1'b0;
    mul_start     = 1'b0;
    mul_busy      = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (w_mul_go) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b0;
            exmem_bubble  = 1'b1;
            mul_start     = 1'b1;
            mul_busy      = 1'b1;
          end else if (w_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (w_load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
          end
        end
        ST_MUL_BUSY: begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_write_en = 1'b0;
          exmem_bubble  = 1'b1;
          mul_busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_stall_inc = ~pc_write_en;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .count (flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_stall_ctrl
// Brief   : Directed scoreboard bench for hazard_stall_ctrl (32-bit and 3-bit
//           counter instances driven in parallel).
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  // ctrl bit order: {pc_we, ifid_we, idex_we, idex_bubble, ifid_flush, exmem_bubble, mul_start, mul_busy}
  localparam logic [7:0] NORM   = 8'b1110_0000;
  localparam logic [7:0] LU     = 8'b0011_0000;
  localparam logic [7:0] RED    = 8'b1111_1000;
  localparam logic [7:0] MSTART = 8'b0000_0111;
  localparam logic [7:0] MBUSY  = 8'b0000_0101;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [2:0]  s_stall;
    logic [2:0]  s_flush;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_valid, ex_RegWrite, ex_MemToReg, ex_mul, ex_redirect;
  logic pc_write_en, ifid_write_en, idex_write_en, idex_bubble;
  logic ifid_flush, exmem_bubble, mul_start, mul_busy;
  logic [31:0] stall_cycles, flush_count;
  logic s_pc, s_ifid, s_idex, s_idexb, s_flushb, s_exmemb, s_start, s_busy;
  logic [2:0] s_stall_cycles, s_flush_count;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
    .ex_mul(ex_mul), .ex_redirect(ex_redirect), .pc_write_en(pc_write_en),
    .ifid_write_en(ifid_write_en), .idex_write_en(idex_write_en),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .exmem_bubble(exmem_bubble),
    .mul_start(mul_start), .mul_busy(mul_busy), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  hazard_stall_ctrl #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
    .ex_mul(ex_mul), .ex_redirect(ex_redirect), .pc_write_en(s_pc),
    .ifid_write_en(s_ifid), .idex_write_en(s_idex), .idex_bubble(s_idexb),
    .ifid_flush(s_flushb), .exmem_bubble(s_exmemb), .mul_start(s_start),
    .mul_busy(s_busy), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  function automatic logic [2:0] sat3(input int v);
    return (v > 7) ? 3'd7 : v[2:0];
  endfunction

  task automatic step(input logic r, input logic iv, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic ev, input logic [4:0] rd, input logic rw,
                      input logic m2r, input logic mul, input logic red,
                      input logic [7:0] exp_ctrl);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; id_valid = iv; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; ex_valid = ev; ex_rd = rd;
    ex_RegWrite = rw; ex_MemToReg = m2r; ex_mul = mul; ex_redirect = red;
    if (r) begin
      m_stall = 0;
      m_flush = 0;
    end
    e.ctrl    = exp_ctrl;
    e.stall   = m_stall;
    e.flush   = m_flush;
    e.s_stall = sat3(m_stall);
    e.s_flush = sat3(m_flush);
    q.push_back(e);
    if (!r) begin
      if (!exp_ctrl[7]) m_stall++;
      if (exp_ctrl[3])  m_flush++;
    end
  endtask

  task automatic idle(input logic r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
  endtask

  task automatic mul_cyc(input logic r, input logic [7:0] exp_ctrl);
    step(r, 1, 1, 2, 1, 1, 1, 8, 1, 0, 1, 0, exp_ctrl);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({pc_write_en, ifid_write_en, idex_write_en, idex_bubble, ifid_flush,
           exmem_bubble, mul_start, mul_busy} !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl @%0t: got %b expected %b", $time,
                 {pc_write_en, ifid_write_en, idex_write_en, idex_bubble, ifid_flush,
                  exmem_bubble, mul_start, mul_busy}, e.ctrl);
      end
      checks++;
      if (stall_cycles !== e.stall || flush_count !== e.flush ||
          s_stall_cycles !== e.s_stall || s_flush_count !== e.s_flush) begin
        errors++;
        $display("FAIL counters @%0t: got stall=%0d flush=%0d sstall=%0d sflush=%0d expected %0d %0d %0d %0d",
                 $time, stall_cycles, flush_count, s_stall_cycles, s_flush_count,
                 e.stall, e.flush, e.s_stall, e.s_flush);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0;
    id_uses_rs2 = 0; ex_valid = 0; ex_rd = 0; ex_RegWrite = 0; ex_MemToReg = 0;
    ex_mul = 0; ex_redirect = 0;
    idle(1);
    idle(1);
    // load-use on rs1, then release
    step(0, 1, 3, 9, 1, 1, 1, 3, 1, 1, 0, 0, LU);
    step(0, 1, 3, 9, 1, 1, 0, 0, 0, 0, 0, 0, NORM);
    // r0, unused rs2, used rs2, link reg, invalid ID, non-load producer
    step(0, 1, 0, 4, 1, 1, 1, 0, 1, 1, 0, 0, NORM);
    step(0, 1, 7, 5, 1, 0, 1, 5, 1, 1, 0, 0, NORM);
    step(0, 1, 7, 5, 1, 1, 1, 5, 1, 1, 0, 0, LU);
    step(0, 1, 31, 2, 1, 1, 1, 31, 1, 1, 0, 0, LU);
    step(0, 0, 6, 6, 1, 1, 1, 6, 1, 1, 0, 0, NORM);
    step(0, 1, 6, 6, 1, 1, 1, 6, 1, 0, 0, 0, NORM);
    // multiply held in EX for MUL_LAT cycles
    mul_cyc(0, MSTART);
    mul_cyc(0, MBUSY);
    mul_cyc(0, MBUSY);
    mul_cyc(0, NORM);
    idle(0);
    // redirect wins over a simultaneous load-use
    step(0, 1, 4, 0, 1, 0, 1, 4, 1, 1, 0, 1, RED);
    idle(0);
    // reset in the second busy cycle, then a fresh sequence
    mul_cyc(0, MSTART);
    mul_cyc(0, MBUSY);
    mul_cyc(1, NORM);
    mul_cyc(0, MSTART);
    mul_cyc(0, MBUSY);
    mul_cyc(0, MBUSY);
    mul_cyc(0, NORM);
    idle(0);
    // push the 3-bit counter past saturation
    for (int i = 0; i < 6; i++) step(0, 1, 3, 9, 1, 1, 1, 3, 1, 1, 0, 0, LU);
    step(0, 1, 4, 0, 1, 0, 1, 4, 1, 1, 0, 1, RED);
    idle(0);
    idle(0);
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
